// File: rtl/spu_sched_pkg.sv
// spu_sched_pkg: scheduler state encoding, engine op codes and cmd_cfg field layout
//   cmd_cfg = {matrix_y, matrix_x, im_base, om_base, ifm_align, ofm_align, shift[3:0], div_m[6:0], div_e[4:0]}
//   address-wide fields start at cfg_off(aw, FLD_*), the three small fields sit in the low 16 bits
package spu_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DONE} state_t;
  localparam logic [1:0] OP_LN = 2'd0;
  localparam logic [1:0] OP_SOFTMAX = 2'd1;
  localparam logic [1:0] OP_GELU = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;
  localparam int OFF_DIV_E = 0;
  localparam int OFF_DIV_M = 5;
  localparam int OFF_SHIFT = 12;
  localparam int FLD_OFM_ALIGN = 0;
  localparam int FLD_IFM_ALIGN = 1;
  localparam int FLD_OM_BASE = 2;
  localparam int FLD_IM_BASE = 3;
  localparam int FLD_MATRIX_X = 4;
  localparam int FLD_MATRIX_Y = 5;
  function automatic int cfg_w(input int aw);
    return 6 * aw + 16;
  endfunction
  function automatic int cfg_off(input int aw, input int fld);
    return 16 + fld * aw;
  endfunction
  localparam int CFG_W = cfg_w(12);
endpackage

// File: rtl/spu_sched_fifo.sv
// spu_sched_fifo: synchronous command queue with flush and a registered full flag
//   core_clk, rst_n (async, active low); push/pop/flush strobes, flush beats a push;
//   din -> dout shows the head entry; full is registered, empty follows the pointers
module spu_sched_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic push_ok, pop_ok;
  assign push_ok = push && !full && !flush;
  assign pop_ok = pop && !empty;
  assign empty = wr_ptr == rd_ptr;
  assign dout = mem[rd_ptr[PW-1:0]];
  assign wr_nxt = wr_ptr + {{PW{1'b0}}, push_ok};
  assign rd_nxt = flush ? wr_ptr : rd_ptr + {{PW{1'b0}}, pop_ok};
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full <= (wr_nxt[PW] != rd_nxt[PW]) && (wr_nxt[PW-1:0] == rd_nxt[PW-1:0]);
    end
  always_ff @(posedge core_clk)
    if (push_ok) mem[wr_ptr[PW-1:0]] <= din;
endmodule

// File: rtl/spu_sched.sv
// spu_sched: queues SPU job descriptors, launches one engine at a time and owns the gbuf port
//   cmd_valid/cmd_ready/cmd_op/cmd_cfg : descriptor intake; sched_flush drops queued jobs
//   eng_start/eng_end/eng_cfg          : one-hot launch, completion pulses, active job config
//   eng_ren..eng_wdata -> gbuf_*       : active engine's port routed in START/RUN only
//   gbuf_rdata -> eng_rdata            : read data broadcast to all engines
//   sched_busy/sched_done/sched_err/sched_timeout : status
//   SPU_SCHED_TIMEOUT_EN : enables the RUN watchdog of TIMEOUT_CYC cycles
module spu_sched
  import spu_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ENG = 4,
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                           core_clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [6*ADDR_WIDTH+15:0]       cmd_cfg,
  input  logic                           sched_flush,
  output logic [NUM_ENG-1:0]             eng_start,
  input  logic [NUM_ENG-1:0]             eng_end,
  output logic [6*ADDR_WIDTH+15:0]       eng_cfg,
  input  logic [NUM_ENG-1:0]             eng_ren,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]  eng_raddr,
  input  logic [NUM_ENG-1:0]             eng_wen,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]  eng_waddr,
  input  logic [NUM_ENG*DATA_WIDTH-1:0]  eng_wdata,
  output logic                           gbuf_ren,
  output logic [ADDR_WIDTH-1:0]          gbuf_raddr,
  output logic                           gbuf_wen,
  output logic [ADDR_WIDTH-1:0]          gbuf_waddr,
  output logic [DATA_WIDTH-1:0]          gbuf_wdata,
  input  logic [DATA_WIDTH-1:0]          gbuf_rdata,
  output logic [DATA_WIDTH-1:0]          eng_rdata,
  output logic                           sched_busy,
  output logic                           sched_done,
  output logic                           sched_err,
  output logic                           sched_timeout
);
  localparam int CW = cfg_w(ADDR_WIDTH);
  state_t state;
  logic [NUM_ENG-1:0] act_oh, head_oh;
  logic [1:0] head_op;
  logic [CW-1:0] head_cfg;
  logic full, empty, push_ok, end_hit, gbuf_en;
  assign cmd_ready = !full;
  assign push_ok = cmd_valid && cmd_ready && !sched_flush;
  // an op beyond NUM_ENG shifts out to an all-zero mask, which marks it as bad
  assign head_oh = NUM_ENG'(1) << head_op;
  assign end_hit = |(eng_end & act_oh);
  assign sched_busy = state != S_IDLE || !empty;
  assign eng_rdata = gbuf_rdata;
  assign gbuf_en = state == S_START || state == S_RUN;
  spu_sched_fifo #(.W(CW + 2), .DEPTH(DEPTH)) u_fifo (
    .core_clk(core_clk),
    .rst_n(rst_n),
    .push(cmd_valid),
    .pop(state == S_LOAD),
    .flush(sched_flush),
    .din({cmd_op, cmd_cfg}),
    .dout({head_op, head_cfg}),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    gbuf_ren = 1'b0;
    gbuf_wen = 1'b0;
    gbuf_raddr = '0;
    gbuf_waddr = '0;
    gbuf_wdata = '0;
    for (int i = 0; i < NUM_ENG; i++)
      if (gbuf_en && act_oh[i]) begin
        gbuf_ren = eng_ren[i];
        gbuf_raddr = eng_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gbuf_wen = eng_wen[i];
        gbuf_waddr = eng_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gbuf_wdata = eng_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end
`ifdef SPU_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic to_hit;
  assign to_hit = to_cnt == 16'(TIMEOUT_CYC - 1);
`else
  assign sched_timeout = 1'b0;
`endif
  always_ff @(posedge core_clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      act_oh <= '0;
      eng_cfg <= '0;
      eng_start <= '0;
      sched_done <= 1'b0;
      sched_err <= 1'b0;
`ifdef SPU_SCHED_TIMEOUT_EN
      to_cnt <= '0;
      sched_timeout <= 1'b0;
`endif
    end else begin
      eng_start <= '0;
      sched_done <= 1'b0;
      sched_err <= 1'b0;
`ifdef SPU_SCHED_TIMEOUT_EN
      if (push_ok) sched_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: if (!empty && !sched_flush) state <= S_LOAD;
        S_LOAD: begin
          eng_cfg <= head_cfg;
          act_oh <= head_oh;
          if (head_oh == '0) begin
            state <= S_DONE;
            sched_done <= 1'b1;
            sched_err <= 1'b1;
          end else begin
            state <= S_START;
            eng_start <= head_oh;
          end
        end
        S_START: begin
          state <= S_RUN;
`ifdef SPU_SCHED_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_RUN:
          if (end_hit) begin
            state <= S_DONE;
            sched_done <= 1'b1;
          end
`ifdef SPU_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            state <= S_DONE;
            sched_done <= 1'b1;
            sched_err <= 1'b1;
            sched_timeout <= 1'b1;
          end else to_cnt <= to_cnt + 16'd1;
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spu_sched.sv
// tb_spu_sched: directed scenario bench for spu_sched (4-engine instance plus a 3-engine instance for bad ops)
module tb_spu_sched;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NE = 4;
  localparam int CW = 6 * AW + 16;
  localparam int MX = 16 + 4 * AW;
  logic core_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 core_clk = ~core_clk;
  logic cmd_valid, cmd_ready, sched_flush;
  logic [1:0] cmd_op;
  logic [CW-1:0] cmd_cfg, eng_cfg;
  logic [NE-1:0] eng_start, eng_end, eng_ren, eng_wen;
  logic [NE*AW-1:0] eng_raddr, eng_waddr;
  logic [NE*DW-1:0] eng_wdata;
  logic gbuf_ren, gbuf_wen;
  logic [AW-1:0] gbuf_raddr, gbuf_waddr;
  logic [DW-1:0] gbuf_wdata, gbuf_rdata, eng_rdata;
  logic sched_busy, sched_done, sched_err, sched_timeout;
  logic c3_valid, c3_ready;
  logic [1:0] c3_op;
  logic [CW-1:0] c3_cfg, e3_cfg;
  logic [2:0] e3_start, e3_end, z3;
  logic [3*AW-1:0] z3a;
  logic [3*DW-1:0] z3d;
  logic g3_ren, g3_wen, d3_busy, d3_done, d3_err, d3_to;
  logic [AW-1:0] g3_raddr, g3_waddr;
  logic [DW-1:0] g3_wdata, e3_rdata;
  int checks = 0;
  int errors = 0;

  spu_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENG(NE), .DEPTH(4), .TIMEOUT_CYC(100)) u_dut (
    .core_clk(core_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cfg(cmd_cfg),
    .sched_flush(sched_flush), .eng_start(eng_start), .eng_end(eng_end), .eng_cfg(eng_cfg),
    .eng_ren(eng_ren), .eng_raddr(eng_raddr), .eng_wen(eng_wen), .eng_waddr(eng_waddr), .eng_wdata(eng_wdata),
    .gbuf_ren(gbuf_ren), .gbuf_raddr(gbuf_raddr), .gbuf_wen(gbuf_wen), .gbuf_waddr(gbuf_waddr),
    .gbuf_wdata(gbuf_wdata), .gbuf_rdata(gbuf_rdata), .eng_rdata(eng_rdata),
    .sched_busy(sched_busy), .sched_done(sched_done), .sched_err(sched_err), .sched_timeout(sched_timeout)
  );

  spu_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENG(3), .DEPTH(4)) u_dut3 (
    .core_clk(core_clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op), .cmd_cfg(c3_cfg),
    .sched_flush(1'b0), .eng_start(e3_start), .eng_end(e3_end), .eng_cfg(e3_cfg),
    .eng_ren(z3), .eng_raddr(z3a), .eng_wen(z3), .eng_waddr(z3a), .eng_wdata(z3d),
    .gbuf_ren(g3_ren), .gbuf_raddr(g3_raddr), .gbuf_wen(g3_wen), .gbuf_waddr(g3_waddr),
    .gbuf_wdata(g3_wdata), .gbuf_rdata(gbuf_rdata), .eng_rdata(e3_rdata),
    .sched_busy(d3_busy), .sched_done(d3_done), .sched_err(d3_err), .sched_timeout(d3_to)
  );

  function automatic logic [CW-1:0] mk_cfg(input logic [AW-1:0] mx, input logic [15:0] lo);
    logic [CW-1:0] c;
    c = '0;
    c[15:0] = lo;
    c[16+3*AW +: AW] = 12'h200;
    c[MX +: AW] = mx;
    c[16+5*AW +: AW] = 12'h00F;
    return c;
  endfunction

  task automatic test_reset();
    cmd_valid = 0; cmd_op = 0; cmd_cfg = '0; sched_flush = 0; eng_end = '0;
    eng_ren = '0; eng_raddr = '0; eng_wen = '0; eng_waddr = '0; eng_wdata = '0; gbuf_rdata = '0;
    c3_valid = 0; c3_op = 0; c3_cfg = '0; e3_end = '0; z3 = '0; z3a = '0; z3d = '0;
    rst_n = 0;
    repeat (2) @(negedge core_clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    checks++; if (eng_start !== 4'b0) begin errors++; $display("FAIL reset_start got %b exp 0000", eng_start); end
    checks++; if (eng_cfg !== '0) begin errors++; $display("FAIL reset_cfg got %h exp 0", eng_cfg); end
    checks++; if ({sched_busy, sched_done, sched_err, sched_timeout} !== 4'b0) begin errors++; $display("FAIL reset_status got %b exp 0000", {sched_busy, sched_done, sched_err, sched_timeout}); end
    checks++; if ({gbuf_ren, gbuf_wen, gbuf_raddr} !== '0) begin errors++; $display("FAIL reset_gbuf got %b/%b/%h exp 0", gbuf_ren, gbuf_wen, gbuf_raddr); end
    rst_n = 1;
    @(negedge core_clk);
    checks++; if ({cmd_ready, sched_busy} !== 2'b10) begin errors++; $display("FAIL reset_release got %b exp 10", {cmd_ready, sched_busy}); end
  endtask

  task automatic test_single_ln();
    logic [CW-1:0] c;
    c = mk_cfg(12'd16, 16'hA5C3);
    cmd_op = 2'd0; cmd_cfg = c; cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0; cmd_cfg = '0;
    checks++; if ({eng_start, sched_busy} !== 5'b0000_1) begin errors++; $display("FAIL ln_push1 start/busy got %b exp 00001", {eng_start, sched_busy}); end
    @(negedge core_clk);
    checks++; if (eng_start !== 4'b0) begin errors++; $display("FAIL ln_push2 start got %b exp 0000", eng_start); end
    @(negedge core_clk);
    checks++; if (eng_start !== 4'b0001) begin errors++; $display("FAIL ln_start got %b exp 0001", eng_start); end
    checks++; if (eng_cfg !== c) begin errors++; $display("FAIL ln_cfg got %h exp %h", eng_cfg, c); end
    eng_end = 4'b0001;
    @(negedge core_clk); eng_end = 4'b0010;
    checks++; if (eng_start !== 4'b0) begin errors++; $display("FAIL ln_start_once got %b exp 0000", eng_start); end
    @(negedge core_clk); eng_end = '0;
    checks++; if ({sched_done, sched_busy} !== 2'b01) begin errors++; $display("FAIL ln_stray_end done/busy got %b exp 01", {sched_done, sched_busy}); end
    repeat (5) @(negedge core_clk);
    eng_end = 4'b0001;
    @(negedge core_clk); eng_end = '0;
    checks++; if ({sched_done, sched_err} !== 2'b10) begin errors++; $display("FAIL ln_done done/err got %b exp 10", {sched_done, sched_err}); end
    checks++; if (eng_cfg[MX +: AW] !== 12'd16) begin errors++; $display("FAIL ln_cfg_hold mx got %0d exp 16", eng_cfg[MX +: AW]); end
    @(negedge core_clk);
    checks++; if ({sched_done, sched_busy} !== 2'b00) begin errors++; $display("FAIL ln_idle done/busy got %b exp 00", {sched_done, sched_busy}); end
  endtask

  task automatic test_mux();
    cmd_op = 2'd1; cmd_cfg = mk_cfg(12'd8, 16'h0001); cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0;
    repeat (2) @(negedge core_clk);
    eng_ren = 4'b0011; eng_raddr[0 +: AW] = 12'h123; eng_raddr[AW +: AW] = 12'h045;
    eng_wen = 4'b0001; eng_waddr[0 +: AW] = 12'h777; eng_waddr[AW +: AW] = 12'h0AB;
    eng_wdata[0 +: DW] = 32'hDEAD0000; eng_wdata[DW +: DW] = 32'hCAFEF00D; gbuf_rdata = 32'h13579BDF;
    #1;
    checks++; if (eng_start !== 4'b0010) begin errors++; $display("FAIL mux_start got %b exp 0010", eng_start); end
    checks++; if ({gbuf_ren, gbuf_raddr} !== {1'b1, 12'h045}) begin errors++; $display("FAIL mux_read got %b/%h exp 1/045", gbuf_ren, gbuf_raddr); end
    checks++; if ({gbuf_wen, gbuf_waddr, gbuf_wdata} !== {1'b0, 12'h0AB, 32'hCAFEF00D}) begin errors++; $display("FAIL mux_write got %b/%h/%h exp 0/0ab/cafef00d", gbuf_wen, gbuf_waddr, gbuf_wdata); end
    checks++; if (eng_rdata !== 32'h13579BDF) begin errors++; $display("FAIL mux_rdata got %h exp 13579bdf", eng_rdata); end
    @(negedge core_clk); eng_wen = 4'b0011; #1;
    checks++; if ({gbuf_wen, gbuf_raddr} !== {1'b1, 12'h045}) begin errors++; $display("FAIL mux_run got %b/%h exp 1/045", gbuf_wen, gbuf_raddr); end
    eng_end = 4'b0010;
    @(negedge core_clk); eng_end = '0;
    checks++; if ({sched_done, gbuf_ren, gbuf_wen, gbuf_raddr} !== 15'h4000) begin errors++; $display("FAIL mux_done got done %b ren %b wen %b raddr %h exp 1/0/0/000", sched_done, gbuf_ren, gbuf_wen, gbuf_raddr); end
    @(negedge core_clk);
    checks++; if ({gbuf_ren, gbuf_wdata} !== '0) begin errors++; $display("FAIL mux_idle got ren %b wdata %h exp 0", gbuf_ren, gbuf_wdata); end
    eng_ren = '0; eng_wen = '0; eng_raddr = '0; eng_waddr = '0; eng_wdata = '0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [NE-1:0] oh;
    int n;
    cmd_op = 2'd2; cmd_cfg = mk_cfg(12'd99, 16'h0BAD); cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0;
    repeat (3) @(negedge core_clk);
    for (int k = 0; k < 4; k++) begin
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", k, cmd_ready); end
      cmd_op = ops[k]; cmd_cfg = mk_cfg(12'(k + 1), 16'(k)); cmd_valid = 1;
      @(negedge core_clk);
    end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b exp 0", cmd_ready); end
    cmd_op = ops[4]; cmd_cfg = mk_cfg(12'd5, 16'd4);
    repeat (3) @(negedge core_clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", cmd_ready); end
    eng_end = 4'b0100;
    n = 0;
    do begin @(negedge core_clk); eng_end = '0; n++; end while (!cmd_ready && n < 20);
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_pop_gap got %0d exp 4", n); end
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << ops[j];
      if (j > 0) begin
        n = 0;
        while (eng_start == '0 && n < 20) begin @(negedge core_clk); n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_gap%0d got %0d exp 3", j, n); end
      end
      checks++; if (eng_start !== oh) begin errors++; $display("FAIL b2b_order%0d got %b exp %b", j, eng_start, oh); end
      checks++; if (eng_cfg[MX +: AW] !== 12'(j + 1)) begin errors++; $display("FAIL b2b_cfg%0d got %0d exp %0d", j, eng_cfg[MX +: AW], j + 1); end
      @(negedge core_clk); cmd_valid = 0; eng_end = oh;
      @(negedge core_clk); eng_end = '0;
      checks++; if (sched_done !== 1'b1) begin errors++; $display("FAIL b2b_done%0d got %b exp 1", j, sched_done); end
    end
    @(negedge core_clk);
    checks++; if ({sched_busy, cmd_ready} !== 2'b01) begin errors++; $display("FAIL b2b_drain busy/ready got %b exp 01", {sched_busy, cmd_ready}); end
  endtask

  task automatic test_flush();
    int starts;
    cmd_op = 2'd0; cmd_cfg = mk_cfg(12'd3, 16'hF1); cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0;
    repeat (3) @(negedge core_clk);
    for (int k = 1; k < 4; k++) begin
      cmd_op = 2'(k); cmd_cfg = mk_cfg(12'(k), 16'hF2); cmd_valid = 1;
      @(negedge core_clk);
    end
    cmd_op = 2'd2; sched_flush = 1;
    @(negedge core_clk); sched_flush = 0; cmd_valid = 0;
    checks++; if ({sched_busy, cmd_ready} !== 2'b11) begin errors++; $display("FAIL flush_run busy/ready got %b exp 11", {sched_busy, cmd_ready}); end
    eng_end = 4'b0001;
    @(negedge core_clk); eng_end = '0;
    checks++; if ({sched_done, sched_err} !== 2'b10) begin errors++; $display("FAIL flush_a_done done/err got %b exp 10", {sched_done, sched_err}); end
    starts = 0;
    repeat (10) begin @(negedge core_clk); if (eng_start != '0) starts++; end
    checks++; if (starts !== 0) begin errors++; $display("FAIL flush_no_start got %0d exp 0", starts); end
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL flush_empty busy got %b exp 0", sched_busy); end
  endtask

  task automatic test_bad_op();
    c3_op = 2'd3; c3_cfg = mk_cfg(12'd7, 16'hBAD0); c3_valid = 1;
    @(negedge core_clk); c3_valid = 0;
    @(negedge core_clk);
    checks++; if ({e3_start, d3_done, d3_busy} !== 5'b000_01) begin errors++; $display("FAIL bad_load start/done/busy got %b exp 00001", {e3_start, d3_done, d3_busy}); end
    @(negedge core_clk);
    checks++; if ({e3_start, d3_done, d3_err} !== 5'b000_11) begin errors++; $display("FAIL bad_op start/done/err got %b exp 00011", {e3_start, d3_done, d3_err}); end
    @(negedge core_clk);
    checks++; if ({d3_done, d3_err, d3_busy} !== 3'b000) begin errors++; $display("FAIL bad_after got %b exp 000", {d3_done, d3_err, d3_busy}); end
    c3_op = 2'd2; c3_valid = 1;
    @(negedge core_clk); c3_valid = 0;
    repeat (2) @(negedge core_clk);
    checks++; if (e3_start !== 3'b100) begin errors++; $display("FAIL bad_good_op got %b exp 100", e3_start); end
    @(negedge core_clk); e3_end = 3'b100;
    @(negedge core_clk); e3_end = '0;
    checks++; if ({d3_done, d3_err} !== 2'b10) begin errors++; $display("FAIL bad_good_done got %b exp 10", {d3_done, d3_err}); end
  endtask

  task automatic test_reset_mid();
    cmd_op = 2'd3; cmd_cfg = mk_cfg(12'd9, 16'h3333); cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0;
    repeat (2) @(negedge core_clk);
    checks++; if (eng_start !== 4'b1000) begin errors++; $display("FAIL mid_start got %b exp 1000", eng_start); end
    @(negedge core_clk); eng_ren = 4'b1000;
    #2 rst_n = 0;
    #1;
    checks++; if ({sched_busy, gbuf_ren, eng_start, cmd_ready} !== 7'b0000001) begin errors++; $display("FAIL mid_reset busy/ren/start/ready got %b exp 0000001", {sched_busy, gbuf_ren, eng_start, cmd_ready}); end
    checks++; if (eng_cfg !== '0) begin errors++; $display("FAIL mid_reset_cfg got %h exp 0", eng_cfg); end
    @(negedge core_clk); rst_n = 1; eng_ren = '0;
    @(negedge core_clk);
  endtask

`ifdef SPU_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    cmd_op = 2'd0; cmd_cfg = mk_cfg(12'd1, 16'h7777); cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0;
    repeat (2) @(negedge core_clk);
    n = 0;
    do begin @(negedge core_clk); n++; end while (!sched_err && n < 200);
    checks++; if (n !== 101) begin errors++; $display("FAIL to_latency got %0d exp 101", n); end
    checks++; if ({sched_done, sched_timeout} !== 2'b11) begin errors++; $display("FAIL to_flags done/timeout got %b exp 11", {sched_done, sched_timeout}); end
    eng_end = 4'b0001;
    @(negedge core_clk); eng_end = '0;
    repeat (3) @(negedge core_clk);
    checks++; if ({sched_done, sched_busy, sched_timeout} !== 3'b001) begin errors++; $display("FAIL to_sticky got %b exp 001", {sched_done, sched_busy, sched_timeout}); end
    cmd_valid = 1;
    @(negedge core_clk); cmd_valid = 0;
    checks++; if (sched_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", sched_timeout); end
    repeat (3) @(negedge core_clk); eng_end = 4'b0001;
    @(negedge core_clk); eng_end = '0;
    checks++; if ({sched_done, sched_err} !== 2'b10) begin errors++; $display("FAIL to_next_job got %b exp 10", {sched_done, sched_err}); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_ln();
    test_mux();
    test_back_to_back();
    test_flush();
    test_bad_op();
    test_reset_mid();
`ifdef SPU_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spu_sched.md
Name: spu_sched

Overview:
Command scheduler for the SPU engines (LayerNorm, softmax, GELU, spare).
- Accepts job descriptors into a small queue and launches one engine at a time with a single start pulse.
- Holds that job's configuration stable on a broadcast config bus and waits for the engine's end pulse.
- Grants the single global-buffer (gbuf) read/write port to the active engine only.
- Sits between the core command decoder and the per-engine SPU tops.

Parameters:
ADDR_WIDTH, 12, gbuf address and matrix-dimension width
DATA_WIDTH, 32, gbuf data width
NUM_ENG, 4, number of attached engines; op codes 0..NUM_ENG-1
DEPTH, 4, command FIFO depth (power of 2, ≥2)
TIMEOUT_CYC, 65535, watchdog limit in cycles (used only with SPU_SCHED_TIMEOUT_EN)

Ports:
core_clk  in  1  process clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  queue can accept; equals !full, registered
cmd_op  in  2  engine select
cmd_cfg  in  6*ADDR_WIDTH+16  packed {matrix_y, matrix_x, im_base, om_base, ifm_align, ofm_align, shift[3:0], div_m[6:0], div_e[4:0]}
sched_flush  in  1  drop all queued, not-yet-loaded descriptors
eng_start  out  NUM_ENG  one-hot start pulse
eng_end  in  NUM_ENG  end pulses from engines
eng_cfg  out  6*ADDR_WIDTH+16  config of the active job
eng_ren  in  NUM_ENG  per-engine read enable
eng_raddr  in  NUM_ENG*ADDR_WIDTH  per-engine read address, flattened
eng_wen  in  NUM_ENG  per-engine write enable
eng_waddr  in  NUM_ENG*ADDR_WIDTH  per-engine write address, flattened
eng_wdata  in  NUM_ENG*DATA_WIDTH  per-engine write data, flattened
gbuf_ren, gbuf_raddr, gbuf_wen, gbuf_waddr, gbuf_wdata  out  1/AW/1/AW/DW  muxed gbuf port
gbuf_rdata  in  DATA_WIDTH  gbuf read data
eng_rdata  out  DATA_WIDTH  gbuf_rdata passed through to all engines
sched_busy  out  1  state != IDLE or queue not empty
sched_done  out  1  one-cycle pulse per retired job
sched_err  out  1  one-cycle pulse: bad op or timeout
sched_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. Queue is empty, state is IDLE, eng_cfg = 0.
- Reset asserted mid-job: immediate return to the reset values. The engine is responsible for its own reset.
- Push: on cmd_valid && cmd_ready, {op, cfg} is written at the rising edge.
- Queue full: cmd_ready = 0. A simultaneous pop does not admit a push in the same cycle.
- Pointer wrap: pointers are log2(DEPTH)+1 bits; full/empty are determined by the MSB compare.
- FSM states IDLE, LOAD, START, RUN, DONE:
  - IDLE: go to LOAD when the queue is not empty.
  - LOAD: pop the head; latch op and cfg into eng_cfg/active_op. If op ≥ NUM_ENG, go to DONE with err; otherwise go to START.
  - START: eng_start[active_op] = 1 for exactly this cycle; go to RUN.
  - RUN: wait for eng_end[active_op]. eng_end on any other bit is ignored. eng_end asserted in the same cycle as START is ignored.
  - DONE: sched_done = 1 (and sched_err = 1 if flagged); go to IDLE.
- Latency: a push accepted at edge N into an idle, empty scheduler gives eng_start high in the cycle after edge N+2. After eng_end is sampled, sched_done follows one cycle later. Minimum gap between back-to-back starts is 4 cycles.
- eng_cfg is stable from START through DONE. It changes only in LOAD.
- gbuf mux: the active engine's ren/raddr/wen/waddr/wdata are routed combinationally in START and RUN only. In all other states gbuf_ren = gbuf_wen = 0 and addresses/data are 0. Inactive engines' enables are ignored. There is no added latency, so the engine's RLATENCY is preserved.
- sched_flush: empties the queue at the next edge. It does not abort a job in LOAD/START/RUN/DONE. Flush wins over a simultaneous push.
- sched_timeout is cleared on the next accepted push.

Optional Feature:
SPU_SCHED_TIMEOUT_EN
- Defined: a 16-bit counter clears on entering RUN and increments each RUN cycle. When it reaches TIMEOUT_CYC, the FSM goes to DONE, sched_err pulses, and sched_timeout sets. A later stray eng_end is ignored.
- Undefined: RUN waits indefinitely and sched_timeout is tied to 0.

Decomposition:
- Package spu_sched_pkg holds:
  - state encodings;
  - op codes OP_LN = 0, OP_SOFTMAX = 1, OP_GELU = 2, OP_RSVD = 3;
  - CFG_W and the field offsets inside cmd_cfg.
- Sub-module spu_sched_fifo: synchronous FIFO with push/pop/flush and a registered full flag.
- FSM and gbuf mux live in the top.

Test Plan:
- Single LN job, op = 0, matrix_x = 16: eng_start = 4'b0001 for exactly one cycle at push + 3. eng_cfg equals the pushed cfg. eng_end at cycle 40 → sched_done at cycle 41, sched_busy drops at cycle 42.
- Push 5 jobs back-to-back with DEPTH = 4 and the engine stalled: cmd_ready = 0 after the 4th push. The 5th is accepted only after the first LOAD pop. Jobs retire in order with op sequence 0,1,2,0,1.
- Mux isolation: during an op = 1 job, drive eng_ren[0] = 1 with raddr 0x123 and eng_ren[1] = 1 with raddr 0x045 → gbuf_raddr = 0x045. In IDLE, gbuf_ren = 0.
- Bad op: set NUM_ENG = 3, push op = 3 → no eng_start, and sched_err and sched_done pulse together.
- Flush with 3 queued jobs while job A is in RUN: A completes normally. The queue ends empty and no further eng_start occurs.
- Timeout with SPU_SCHED_TIMEOUT_EN and TIMEOUT_CYC = 100, engine never ends: sched_err fires after 100 RUN cycles and sched_timeout stays 1 until the next push.
